// File: rtl/rice_core_pkg.sv
// rtl/rice_core_pkg.sv - shared core pipeline types and constants.
`ifndef RICE_CORE_PKG_TYPES_GUARD
`define RICE_CORE_PKG_TYPES_GUARD
`define RICE_CORE_DEFINE_TYPES(xlen) \
    typedef logic [(xlen)-1:0] rice_core_pc; \
    typedef logic [31:0] rice_core_inst; \
    typedef struct packed { \
        logic          valid; \
        rice_core_pc   pc; \
        rice_core_inst inst; \
    } rice_core_if_result;
`endif

package rice_core_pkg;
    localparam int RICE_CORE_XLEN       = 32;
    localparam int RICE_CORE_INST_BYTES = 4;
    `RICE_CORE_DEFINE_TYPES(RICE_CORE_XLEN)
endpackage

// File: rtl/rice_core_pipeline_if.sv
// rtl/rice_core_pipeline_if.sv - IF-stage view of the core pipeline control bundle.
interface rice_core_pipeline_if;
    import rice_core_pkg::*;

    logic               stall;
    logic               flush;
    rice_core_pc        flush_pc;
    rice_core_if_result if_result;

    modport if_stage (input stall, input flush, input flush_pc, output if_result);
    modport id_stage (output stall, output flush, output flush_pc, input if_result);
endinterface

// File: rtl/rice_core_fetch_queue.sv
// rtl/rice_core_fetch_queue.sv - synchronous prefetch FIFO of {pc, inst}; clear beats push.
module rice_core_fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    typedef logic [PTR_W-1:0] ptr_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic ptr_t ptr_next(ptr_t p);
        return (p == ptr_t'(DEPTH-1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CNT_W'(DEPTH));

    always_comb begin
        do_push  = i_push && !i_clear;
        do_pop   = i_pop && !o_empty && !i_clear;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = i_wdata;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Storage needs no reset: nothing is read before it has been written.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !i_clear && o_full && !i_pop));
endmodule

// File: rtl/rice_core_fetch_stage.sv
// rtl/rice_core_fetch_stage.sv - instruction fetch stage: credit-limited in-order requests,
// prefetch queue, registered {valid, pc, inst} to ID, flush with in-flight response discard.
module rice_core_fetch_stage
    import rice_core_pkg::*;
#(
    parameter int              XLEN            = RICE_CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              QUEUE_DEPTH     = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_inst_request_valid,
    input  logic               i_inst_request_ready,
    output logic [XLEN-1:0]    o_inst_request_address,
    input  logic               i_inst_response_valid,
    input  logic [31:0]        i_inst_response_data,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic [XLEN-1:0]    i_flush_pc,
    output rice_core_if_result o_if_result
);
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING+1);
    localparam int QCNT_W  = $clog2(QUEUE_DEPTH+1);
    localparam int SUM_W   = ((CNT_W > QCNT_W) ? CNT_W : QCNT_W) + 1;
    localparam int ENTRY_W = XLEN + 32;
    typedef logic [CNT_W-1:0] cnt_t;

    rice_core_pipeline_if pipe_if ();

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]    resp_pc_q, resp_pc_d;
    cnt_t               outstanding_q, outstanding_d;
    cnt_t               discard_q, discard_d;
    logic               run_q, run_d;
    rice_core_if_result if_result_q, if_result_d;

    logic [XLEN-1:0]    flush_target;
    logic [SUM_W-1:0]   in_flight;
    logic               req_valid, req_fire, resp_live, out_load;
    logic               q_push, q_pop, q_empty, q_full;
    logic [QCNT_W-1:0]  q_count;
    logic [ENTRY_W-1:0] q_rdata, q_wdata;

    assign pipe_if.stall    = i_stall;
    assign pipe_if.flush    = i_flush;
    assign pipe_if.flush_pc = i_flush_pc;
    assign pipe_if.if_result = if_result_q;
    assign o_if_result      = pipe_if.if_result;

    assign o_inst_request_valid   = req_valid;
    assign o_inst_request_address = fetch_pc_q;

    rice_core_fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (q_push),
        .i_pop   (q_pop),
        .i_clear (pipe_if.flush),
        .i_wdata (q_wdata),
        .o_rdata (q_rdata),
        .o_count (q_count),
        .o_empty (q_empty),
        .o_full  (q_full)
    );

    always_comb begin
        flush_target = pipe_if.flush_pc & ~XLEN'(3);
        in_flight    = SUM_W'(outstanding_q) + SUM_W'(q_count);
        // Requests depend only on state and flush, never on the response bus.
        req_valid = run_q && !pipe_if.flush
                    && (outstanding_q < cnt_t'(MAX_OUTSTANDING))
                    && (in_flight < SUM_W'(QUEUE_DEPTH));
        req_fire  = req_valid && i_inst_request_ready;
        resp_live = i_inst_response_valid && (discard_q == '0) && !pipe_if.flush;
        out_load  = !pipe_if.stall || !if_result_q.valid;
        q_pop     = out_load && !q_empty && !pipe_if.flush;
        q_push    = resp_live && !(out_load && q_empty);
        q_wdata   = {resp_pc_q, i_inst_response_data};

        run_d         = 1'b1;
        outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(i_inst_response_valid);
        fetch_pc_d    = req_fire ? fetch_pc_q + XLEN'(RICE_CORE_INST_BYTES) : fetch_pc_q;
        resp_pc_d     = resp_live ? resp_pc_q + XLEN'(RICE_CORE_INST_BYTES) : resp_pc_q;
        discard_d     = (i_inst_response_valid && discard_q != '0) ? discard_q - cnt_t'(1)
                                                                   : discard_q;
        if_result_d   = if_result_q;

        if (pipe_if.flush) begin
            fetch_pc_d        = flush_target;
            resp_pc_d         = flush_target;
            discard_d         = outstanding_d;
            if_result_d.valid = 1'b0;
        end else if (out_load) begin
            if (!q_empty) begin
                if_result_d.valid = 1'b1;
                {if_result_d.pc, if_result_d.inst} = q_rdata;
            end else if (resp_live) begin
                if_result_d.valid = 1'b1;
                if_result_d.pc    = resp_pc_q;
                if_result_d.inst  = i_inst_response_data;
            end else begin
                if_result_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            run_q         <= 1'b0;
            if_result_q   <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            run_q         <= run_d;
            if_result_q   <= if_result_d;
        end
    end

    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_inst_response_valid |-> (outstanding_q != '0));
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        discard_q <= outstanding_q);
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        q_push |-> (!q_full || q_pop));
endmodule
